// File: rtl/prim_alert_ping_sched_pkg.sv
// Shared types and helpers for the alert ping scheduler.
// State encoding is fixed so the values stay stable across tools and netlists.
package prim_alert_ping_sched_pkg;

  typedef logic [1:0] ping_sched_state_e;

  localparam ping_sched_state_e StIdle = 2'b00;
  localparam ping_sched_state_e StWait = 2'b01;
  localparam ping_sched_state_e StPing = 2'b10;

  // Index width, never below one bit so single-channel builds still have a port.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prim_rr_next_idx.sv
// Round-robin search: first set mask bit strictly above ptr, wrapping around.
// ptr itself is examined last, so a lone set bit at ptr is picked again.
module prim_rr_next_idx
  import prim_alert_ping_sched_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = idx_width(N)
) (
  input  logic [N-1:0]    mask,
  input  logic [IdxW-1:0] ptr,
  output logic [IdxW-1:0] idx,
  output logic            valid
);

  always_comb begin
    int unsigned cand;
    cand  = 0;
    idx   = ptr;
    valid = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(ptr) + k) % N;
      if (!valid && ((mask >> cand) & N'(1)) != '0) begin
        valid = 1'b1;
        idx   = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/prim_alert_ping_sched.sv
// Periodic round-robin ping scheduler for a bank of alert receivers.
// Waits, pings one unmasked channel, then reports timeouts and unexpected ping_ok pulses.
module prim_alert_ping_sched
  import prim_alert_ping_sched_pkg::*;
#(
  parameter int unsigned NAlerts = 4,
  parameter int unsigned CntW    = 16,
  localparam int unsigned IdxW   = idx_width(NAlerts)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [NAlerts-1:0] alert_mask_i,
  input  logic [CntW-1:0]    wait_cyc_i,
  input  logic [CntW-1:0]    timeout_cyc_i,
  input  logic [NAlerts-1:0] ping_ok_i,
  output logic [NAlerts-1:0] ping_en_o,
  output logic               ping_fail_o,
  output logic [IdxW-1:0]    fail_idx_o,
  output logic               spurious_o
);

  localparam logic [IdxW-1:0] PtrRst = IdxW'(NAlerts - 1);

  ping_sched_state_e  state_q, state_d;
  logic [CntW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [CntW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [CntW-1:0]    tmo_lim_q, tmo_lim_d;
  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [IdxW-1:0]    fail_idx_q, fail_idx_d;
  logic [NAlerts-1:0] ping_en_q, ping_en_d;
  logic               fail_q, fail_d;
  logic               spurious_q, spurious_d;

  logic [IdxW-1:0]    rr_idx;
  logic               rr_valid;
  logic [NAlerts-1:0] ptr_onehot, active_mask;
  logic               armed, ok_hit, tmo_hit;

  prim_rr_next_idx #(
    .N    (NAlerts),
    .IdxW (IdxW)
  ) u_rr (
    .mask  (alert_mask_i),
    .ptr   (ptr_q),
    .idx   (rr_idx),
    .valid (rr_valid)
  );

  // The pointer doubles as the active index while in StPing.
  assign ptr_onehot  = NAlerts'(1) << ptr_q;
  assign active_mask = (state_q == StPing) ? ptr_onehot : '0;
  assign armed       = |ping_en_q;
  assign ok_hit      = armed && |(ping_ok_i & ptr_onehot);
  assign tmo_hit     = armed && (tmo_cnt_q == tmo_lim_q);
  assign spurious_d  = |(ping_ok_i & ~active_mask);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    tmo_lim_d  = tmo_lim_q;
    ptr_d      = ptr_q;
    ping_en_d  = ping_en_q;
    fail_d     = 1'b0;
    fail_idx_d = '0;

    if (!en_i) begin
      state_d   = StIdle;
      ping_en_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d    = StWait;
          wait_cnt_d = wait_cyc_i;
        end
        StWait: begin
          if (wait_cnt_q != '0) begin
            wait_cnt_d = wait_cnt_q - CntW'(1);
          end else if (rr_valid) begin
            state_d   = StPing;
            ptr_d     = rr_idx;
            tmo_cnt_d = '0;
            // Limit is latched here so timeout edits cannot disturb an active ping.
            tmo_lim_d = (timeout_cyc_i == '0) ? '0 : timeout_cyc_i - CntW'(1);
          end else begin
            wait_cnt_d = wait_cyc_i;
          end
        end
        StPing: begin
          if (!armed) begin
            // First cycle in StPing only raises the request.
            ping_en_d = ptr_onehot;
          end else if (ok_hit) begin
            ping_en_d  = '0;
            state_d    = StWait;
            wait_cnt_d = wait_cyc_i;
          end else if (tmo_hit) begin
            ping_en_d  = '0;
            fail_d     = 1'b1;
            fail_idx_d = ptr_q;
            state_d    = StWait;
            wait_cnt_d = wait_cyc_i;
          end else if (tmo_cnt_q != '1) begin
            tmo_cnt_d = tmo_cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d   = StIdle;
          ping_en_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      tmo_lim_q  <= '0;
      ptr_q      <= PtrRst;
      ping_en_q  <= '0;
      fail_q     <= 1'b0;
      fail_idx_q <= '0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_lim_q  <= tmo_lim_d;
      ptr_q      <= ptr_d;
      ping_en_q  <= ping_en_d;
      fail_q     <= fail_d;
      fail_idx_q <= fail_idx_d;
      spurious_q <= spurious_d;
    end
  end

  assign ping_en_o   = ping_en_q;
  assign ping_fail_o = fail_q;
  assign fail_idx_o  = fail_idx_q;
  assign spurious_o  = spurious_q;

endmodule
